// File: rtl/switch_calc_core_if.sv
// Operand/operator entry and result bus for the switch calculator.
interface switch_calc_core_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   num;
  logic [1:0]         op;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               neg;
  logic               err;
  logic [2:0]         state;
  logic               valid;

  modport master (
    output num, op, done,
    input  result, neg, err, state, valid
  );

  modport slave (
    input  num, op, done,
    output result, neg, err, state, valid
  );
endinterface

// File: rtl/switch_calc_core.sv
// Push-button calculator: enter A, operator, B; computes add/sub/mul/div
// (restoring divider, one quotient bit per cycle) and holds the result.
module switch_calc_core #(
  parameter int WIDTH  = 4,
  parameter int DIV_EN = 1
) (
  input  logic               CLK,
  input  logic               reset,
  switch_calc_core_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit DIV_OFF = (DIV_EN == 0);

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OPR  = 3'd1,
    S_OP2  = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t st, st_nxt;

  // done synchronizer + rising-edge detect
  logic       s1, s2, s3, arm;
  logic [1:0] fill;
  logic       enter;

  // The edge detector only arms after the chain has filled and seen done
  // low, so a button held through reset release never counts as a press.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      arm  <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1 <= bus.done;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && !s2) arm <= 1'b1;
    end
  end

  assign enter = arm & s2 & ~s3;

  // operands, divider, outputs
  logic [WIDTH-1:0] a, b, rem, quo;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    result_q;
  logic             neg_q, err_q;

  logic             is_div, div_bad;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [W2-1:0]    calc_res;
  logic             calc_neg;

  assign is_div  = (op_r == 2'b11);
  assign div_bad = DIV_OFF || (b == '0);

  // One restoring step: shift in the next dividend bit, subtract B if it fits.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, b};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    calc_res = '0;
    calc_neg = 1'b0;
    case (op_r)
      2'b00: calc_res = W2'(a) + W2'(b);
      2'b01: begin
        if (a < b) begin
          calc_res = W2'(b - a);
          calc_neg = 1'b1;
        end else begin
          calc_res = W2'(a - b);
        end
      end
      2'b10: calc_res = W2'(a) * W2'(b);
      default: calc_res = {rem_nxt, quo_nxt};
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st <= S_OP1;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_OP1:  if (enter) st_nxt = S_OPR;
      S_OPR:  if (enter) st_nxt = S_OP2;
      S_OP2:  if (enter) st_nxt = S_CALC;
      S_CALC: begin
        if (!is_div)          st_nxt = S_SHOW;
        else if (div_bad)     st_nxt = S_ERR;
        else if (cnt == LAST) st_nxt = S_SHOW;
      end
      S_SHOW: if (enter) st_nxt = S_OP1;
      S_ERR:  if (enter) st_nxt = S_OP1;
      default: st_nxt = S_OP1;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      a        <= '0;
      b        <= '0;
      op_r     <= 2'b00;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (st)
        S_OP1: if (enter) a <= bus.num;
        S_OPR: if (enter) op_r <= bus.op;
        S_OP2: if (enter) begin
          b   <= bus.num;
          rem <= '0;
          quo <= a;
          cnt <= '0;
        end
        S_CALC: begin
          if (!is_div) begin
            result_q <= calc_res;
            neg_q    <= calc_neg;
          end else if (div_bad) begin
            result_q <= '1;
            neg_q    <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CW'(1);
            // result only becomes visible once the final bit is resolved
            if (cnt == LAST) begin
              result_q <= calc_res;
              neg_q    <= 1'b0;
            end
          end
        end
        S_SHOW, S_ERR: if (enter) begin
          a        <= '0;
          b        <= '0;
          op_r     <= 2'b00;
          rem      <= '0;
          quo      <= '0;
          cnt      <= '0;
          result_q <= '0;
          neg_q    <= 1'b0;
          err_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
  assign bus.state  = st;
  assign bus.valid  = (st == S_SHOW) || (st == S_ERR);
endmodule

// File: tb/tb_switch_calc_core.sv
// Directed scoreboard bench for switch_calc_core (WIDTH=4, DIV_EN=1).
module tb_switch_calc_core;
  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  switch_calc_core_if #(.WIDTH(4)) bus ();

  switch_calc_core #(.WIDTH(4), .DIV_EN(1)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] res;
    logic       neg;
    logic       err;
  } exp_t;

  exp_t q[$];
  logic valid_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: on each new valid result, pop the oldest expectation and compare.
  always @(negedge CLK) begin
    exp_t g, e;
    if (reset && bus.valid && !valid_d) begin
      g = '{bus.state, bus.result, bus.neg, bus.err};
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", g);
      end else begin
        e = q.pop_front();
        chk("result{st,res,neg,err}", 32'(g), 32'(e));
      end
    end
    valid_d = bus.valid;
  end

  task automatic push(input logic [2:0] st, input logic [7:0] res, input logic n, input logic e);
    exp_t x;
    x = '{st, res, n, e};
    q.push_back(x);
  endtask

  task automatic press(input logic [3:0] n, input logic [1:0] o);
    bus.num  = n;
    bus.op   = o;
    bus.done = 1'b1;
    repeat (5) @(posedge CLK);
    #1 bus.done = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic calc(input logic [3:0] av, input logic [1:0] o, input logic [3:0] bv,
                      input logic [2:0] st, input logic [7:0] res, input logic n, input logic e);
    press(av, 2'b00);
    press(4'd0, o);
    push(st, res, n, e);
    press(bv, 2'b00);
  endtask

  task automatic clear_chk(input string name);
    press(4'd0, 2'b00);
    chk({name, "_clr_state"}, 32'(bus.state), 0);
    chk({name, "_clr_out"}, {bus.result, bus.neg, bus.err, bus.valid}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset    = 1'b0;
    bus.num  = '0;
    bus.op   = '0;
    bus.done = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_out", {bus.result, bus.neg, bus.err, bus.valid}, 0);
    reset = 1'b1;
    repeat (5) @(posedge CLK);
    #1;

    // Add 9+8 with enter-latency checks on the first operand
    bus.num  = 4'd9;
    bus.done = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("enter_not_at_2nd_edge", 32'(bus.state), 0);
    @(posedge CLK); #1;
    chk("enter_at_3rd_edge", 32'(bus.state), 1);
    repeat (3) @(posedge CLK);
    #1;
    chk("held_done_one_pulse", 32'(bus.state), 1);
    bus.done = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    press(4'd0, 2'b00);
    push(3'd4, 8'd17, 1'b0, 1'b0);
    press(4'd8, 2'b00);
    clear_chk("add");

    calc(4'd3, 2'b01, 4'd10, 3'd4, 8'd7, 1'b1, 1'b0);
    clear_chk("sub_neg");
    calc(4'd10, 2'b01, 4'd3, 3'd4, 8'd7, 1'b0, 1'b0);
    clear_chk("sub_pos");
    calc(4'd5, 2'b01, 4'd5, 3'd4, 8'd0, 1'b0, 1'b0);
    clear_chk("sub_eq");
    calc(4'd15, 2'b10, 4'd15, 3'd4, 8'hE1, 1'b0, 1'b0);
    clear_chk("mul_max");

    // Divide 14/4, counting cycles spent in S_CALC
    press(4'd14, 2'b00);
    press(4'd0, 2'b11);
    push(3'd4, 8'h23, 1'b0, 1'b0);
    bus.num  = 4'd4;
    bus.done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i == 5) bus.done = 1'b0;
      if (bus.state == 3'd3) cnt++;
      if (bus.valid) break;
    end
    bus.done = 1'b0;
    chk("div_calc_cycles", 32'(cnt), 4);
    repeat (4) @(posedge CLK);
    #1;
    clear_chk("div");

    calc(4'd5, 2'b11, 4'd0, 3'd5, 8'hFF, 1'b0, 1'b1);
    clear_chk("div0");

    // 13/2 with a second press landing mid-divide; it must be dropped
    press(4'd13, 2'b00);
    press(4'd0, 2'b11);
    push(3'd4, 8'h16, 1'b0, 1'b0);
    bus.num  = 4'd2;
    bus.done = 1'b1;
    @(posedge CLK); #1 bus.done = 1'b0;
    @(posedge CLK); #1 bus.done = 1'b1;
    @(posedge CLK); #1 bus.done = 1'b0;
    chk("div13_in_calc", 32'(bus.state), 3);
    repeat (8) @(posedge CLK);
    #1;
    chk("div13_press_ignored", 32'(bus.state), 4);
    chk("div13_stable", 32'(bus.result), 32'h16);
    clear_chk("div13");

    // Reset asserted in the 2nd S_CALC cycle, done held across release
    press(4'd14, 2'b00);
    press(4'd0, 2'b11);
    bus.num  = 4'd4;
    bus.done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.state == 3'd3) break;
    end
    chk("rst_reach_calc", 32'(bus.state), 3);
    @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_state", 32'(bus.state), 0);
    chk("rst_async_out", {bus.result, bus.neg, bus.err, bus.valid}, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("rst_done_held_no_adv", 32'(bus.state), 0);
    bus.done = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    calc(4'd1, 2'b00, 4'd2, 3'd4, 8'd3, 1'b0, 1'b0);
    clear_chk("post_rst");

    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/switch_calc_core.md
SWITCH_CALC_CORE -- requirements
Module: switch_calc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (2..16).
REQ-002 SHALL have parameter DIV_EN, default 1, 1 = divide implemented, 0 = op 11 reports error.
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port num  input  WIDTH  switch operand value.
REQ-006 SHALL have port op  input  2  operator: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have port done  input  1  asynchronous push-button "enter".
REQ-008 SHALL have port result  output  2*WIDTH  unsigned result magnitude.
REQ-009 SHALL have port neg  output  1  result is negative (sub only).
REQ-010 SHALL have port err  output  1  error: divide by zero, or div with DIV_EN=0.
REQ-011 SHALL have port state  output  3  current FSM state encoding.
REQ-012 SHALL have port valid  output  1  result/neg/err are final.

Function
REQ-013 SHALL pass done through a 2-flop synchronizer, then generate a one-cycle enter pulse on its 0->1 transition.
- Pulse asserts in the 3rd rising CLK edge after done rises.
- Holding done high generates exactly one pulse.
REQ-014 SHALL implement FSM states: S_OP1=0, S_OPR=1, S_OP2=2, S_CALC=3, S_SHOW=4, S_ERR=5.
- Codes 6 and 7 SHALL go to S_OP1 on the next edge.
REQ-015 SHALL, in S_OP1 on enter, latch num into operand A and go to S_OPR.
REQ-016 SHALL, in S_OPR on enter, latch op and go to S_OP2.
REQ-017 SHALL, in S_OP2 on enter, latch num into operand B and go to S_CALC.
REQ-018 SHALL, for add, compute A+B zero-extended to 2*WIDTH with neg=0.
- Go to S_SHOW one cycle after S_CALC entry.
REQ-019 SHALL, for sub, set neg=1 and result=B-A when A<B; otherwise neg=0 and result=A-B.
- Single cycle to S_SHOW.
REQ-020 SHALL, for mul, compute the full A*B product in 2*WIDTH bits.
- Single cycle to S_SHOW.
REQ-021 SHALL, for div with B!=0, use a restoring divider.
- Exactly WIDTH cycles spent in S_CALC.
- result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
REQ-022 SHALL, for div with B==0 (or DIV_EN=0), go from S_CALC to S_ERR in one cycle.
- err=1, result=all ones, neg=0.
REQ-023 SHALL hold valid=1 only in S_SHOW and S_ERR; result, neg and err SHALL be stable while valid=1.
REQ-024 SHALL ignore enter pulses while in S_CALC; the pulse is not queued.
REQ-025 SHALL, on enter in S_SHOW or S_ERR, go to S_OP1 and clear result, neg, err and operands.
REQ-026 SHALL ignore num and op changes except on the enter cycle of the capturing state.

Reset
REQ-027 SHALL, while reset=0 (asynchronously), force the following and hold them until reset=1:
- state=S_OP1
- result=0, neg=0, err=0, valid=0
- operands, divider and synchronizer flops cleared
REQ-028 SHALL abort any division in progress when reset asserts mid-operation, with no partial result visible.
REQ-029 SHALL NOT generate an enter pulse on the first edge after reset release if done is held high across reset.

Verification
REQ-030 Add: WIDTH=4; enter 9, op 00, enter 8 -> S_SHOW, result=17, neg=0, valid=1.
REQ-031 Sub negative: enter 3, op 01, enter 10 -> result=7, neg=1; then enter -> state=0, result=0.
REQ-032 Mul max: enter 15, op 10, enter 15 -> result=225 (8'hE1).
REQ-033 Div: enter 14, op 11, enter 4 -> exactly 4 cycles in S_CALC, then result=8'h23 (rem 2, quo 3).
REQ-034 Div by zero: enter 5, op 11, enter 0 -> state=5, err=1, result=8'hFF; a done pulse during S_CALC of a 13/2 divide is ignored.
REQ-035 Reset mid-divide: assert reset=0 in the 2nd S_CALC cycle -> all outputs 0 immediately, state=0.
- Done held high through reset release -> no state advance.
